// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the unified-memory arbiter.
//   - FSM state encoding
//   - default address/data widths and watchdog limit
//   - grant-bit constants for the round-robin "last" register
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: access timeout counter for the memory arbiter.
// Only instantiated when MEM_ARB_WDOG_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (new access issued)
//   tick      - one busy cycle elapsed without memory completion
//   expired   - high in the tick cycle that makes TIMEOUT busy cycles
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // The count holds the number of already-elapsed busy cycles, so the
  // TIMEOUT-th busy cycle is the one that sees TIMEOUT-1.
  assign expired = tick && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (tick && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-ported multi-cycle memory between the
// fetch stage (instruction reads) and the memory stage (loads/stores).
// Optional watchdog: define MEM_ARB_WDOG_EN to time out stuck accesses.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   i_req/i_addr -> i_rdata/i_done    - fetch request / response
//   i_stall                           - fetch freeze
//   d_rd/d_wr/d_addr/d_wdata          - data request
//   d_rdata/d_done/d_stall            - data response / freeze
//   m_en/m_wr/m_addr/m_wdata          - memory issue side
//   m_rdata/m_done                    - memory completion side
//   err                               - rd+wr conflict, or sticky timeout
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no access outstanding; issue on any request
// BUSY_I  | instruction read outstanding, waiting m_done
// BUSY_D  | data read/write outstanding, waiting m_done
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  output logic              err
);

  state_e            r_state, w_state_nxt;
  logic              r_last, w_last_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;

  logic              w_d_req;
  logic              w_load;
  logic              w_i_done, w_d_done;
  logic              w_expired;
  logic              w_err_wdog;
  logic [DATA_W-1:0] w_rdata;

  assign w_d_req = d_rd | d_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    m_en        = 1'b0;
    m_wr        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    case (r_state)
      ST_IDLE: begin
        // Gate issue during reset so nothing reaches memory while rst is high.
        if (!rst) begin
          if (w_d_req && (!i_req || r_last == GRANT_I)) begin
            m_en        = 1'b1;
            m_wr        = d_wr;  // rd+wr together is treated as a write
            m_addr      = d_addr;
            m_wdata     = d_wdata;
            w_load      = 1'b1;
            w_last_nxt  = GRANT_D;
            w_state_nxt = ST_BUSY_D;
          end else if (i_req) begin
            m_en        = 1'b1;
            m_addr      = i_addr;
            w_load      = 1'b1;
            w_last_nxt  = GRANT_I;
            w_state_nxt = ST_BUSY_I;
          end
        end
      end
      ST_BUSY_I: begin
        m_wr    = r_wr;
        m_addr  = r_addr;
        m_wdata = r_wdata;
        if (m_done || w_expired) begin
          w_i_done    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        m_wr    = r_wr;
        m_addr  = r_addr;
        m_wdata = r_wdata;
        if (m_done || w_expired) begin
          w_d_done    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= GRANT_I;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (w_load) begin
        r_addr  <= m_addr;
        r_wdata <= m_wdata;
        r_wr    <= m_wr;
      end
    end
  end

`ifdef MEM_ARB_WDOG_EN
  logic r_err_wdog;

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (m_en),
    .tick    ((r_state != ST_IDLE) && !m_done),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_wdog <= 1'b0;
    end else if (w_expired) begin
      r_err_wdog <= 1'b1;
    end
  end

  assign w_err_wdog = r_err_wdog;
`else
  assign w_expired  = 1'b0;
  assign w_err_wdog = 1'b0;
`endif

  // A timed-out access returns zero instead of whatever is on m_rdata.
  assign w_rdata = w_expired ? '0 : m_rdata;

  assign i_done  = w_i_done;
  assign d_done  = w_d_done;
  assign i_rdata = w_i_done ? w_rdata : '0;
  assign d_rdata = w_d_done ? w_rdata : '0;
  assign i_stall = i_req & ~w_i_done;
  assign d_stall = w_d_req & ~w_d_done;
  assign err     = (d_rd & d_wr) | w_err_wdog;

endmodule
